// File: rtl/morse_char_uart_tx_pkg.sv
// Shared encodings for the Morse character UART stage: symbol pairs,
// ASCII constants and the transmitter state type.
package morse_char_uart_tx_pkg;

    typedef logic [9:0] code_t;

    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b10;
    localparam logic [1:0] SYM_DASH = 2'b11;

    localparam logic [7:0] CH_SPACE   = 8'h20;
    localparam logic [7:0] CH_INVALID = 8'h3F;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/morse_char_uart_tx_if.sv
// Code-side handshake between the keyer (master) and the character
// transmitter (slave).
interface morse_char_uart_tx_if;
    import morse_char_uart_tx_pkg::*;

    code_t code_in;
    logic  code_valid;
    logic  code_ready;

    modport master (output code_in, output code_valid, input  code_ready);
    modport slave  (input  code_in, input  code_valid, output code_ready);

endinterface

// File: rtl/morse_char_uart_tx_lut.sv
// Combinational Morse decode: strips leading empty pairs, then maps the
// dot/dash sequence to ASCII, flagging gaps or unknown patterns as '?'.
module morse_lut
    import morse_char_uart_tx_pkg::*;
(
    input  code_t      code_in,
    output logic [7:0] ascii,
    output logic       invalid
);

    logic [2:0] len;
    logic [4:0] dash;
    logic       bad;
    logic [7:0] ch;

    always_comb begin
        len  = '0;
        dash = '0;
        bad  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (code_in[2*i +: 2] != SYM_NONE) len = 3'(i + 1);
        end
        // Below the first symbol every pair must be a real dot or dash.
        for (int i = 0; i < 5; i++) begin
            if (i < int'(len)) begin
                if (!code_in[2*i + 1]) bad = 1'b1;
                dash[i] = code_in[2*i];
            end
        end
    end

    // Key: length, then first-sent symbol in the MSB, dash = 1.
    always_comb begin
        ch = 8'h00;
        case ({len, dash})
            {3'd1, 5'b00000}: ch = "E";
            {3'd1, 5'b00001}: ch = "T";
            {3'd2, 5'b00000}: ch = "I";
            {3'd2, 5'b00001}: ch = "A";
            {3'd2, 5'b00010}: ch = "N";
            {3'd2, 5'b00011}: ch = "M";
            {3'd3, 5'b00000}: ch = "S";
            {3'd3, 5'b00001}: ch = "U";
            {3'd3, 5'b00010}: ch = "R";
            {3'd3, 5'b00011}: ch = "W";
            {3'd3, 5'b00100}: ch = "D";
            {3'd3, 5'b00101}: ch = "K";
            {3'd3, 5'b00110}: ch = "G";
            {3'd3, 5'b00111}: ch = "O";
            {3'd4, 5'b00000}: ch = "H";
            {3'd4, 5'b00001}: ch = "V";
            {3'd4, 5'b00010}: ch = "F";
            {3'd4, 5'b00100}: ch = "L";
            {3'd4, 5'b00110}: ch = "P";
            {3'd4, 5'b00111}: ch = "J";
            {3'd4, 5'b01000}: ch = "B";
            {3'd4, 5'b01001}: ch = "X";
            {3'd4, 5'b01010}: ch = "C";
            {3'd4, 5'b01011}: ch = "Y";
            {3'd4, 5'b01100}: ch = "Z";
            {3'd4, 5'b01101}: ch = "Q";
            {3'd5, 5'b11111}: ch = "0";
            {3'd5, 5'b01111}: ch = "1";
            {3'd5, 5'b00111}: ch = "2";
            {3'd5, 5'b00011}: ch = "3";
            {3'd5, 5'b00001}: ch = "4";
            {3'd5, 5'b00000}: ch = "5";
            {3'd5, 5'b10000}: ch = "6";
            {3'd5, 5'b11000}: ch = "7";
            {3'd5, 5'b11100}: ch = "8";
            {3'd5, 5'b11110}: ch = "9";
            default:          ch = 8'h00;
        endcase
    end

    always_comb begin
        ascii   = ch;
        invalid = 1'b0;
        if (len == 3'd0) begin
            ascii = CH_SPACE;
        end else if (bad || ch == 8'h00) begin
            ascii   = CH_INVALID;
            invalid = 1'b1;
        end
    end

endmodule

// File: rtl/morse_char_uart_tx.sv
// Morse character stage: decodes finished symbol vectors, queues the ASCII
// in a small FIFO and sends each character as an 8N1 UART frame.
module morse_char_uart_tx
    import morse_char_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int BAUD        = 9600,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    morse_char_uart_tx_if.slave         code_if,
    output logic [7:0]                  char_out,
    output logic                        char_valid,
    output logic                        err_invalid,
    output logic                        overflow,
    output logic                        tx,
    output logic                        tx_busy
);

    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    logic [7:0] lut_ascii;
    logic       lut_invalid;

    morse_lut u_lut (
        .code_in (code_if.code_in),
        .ascii   (lut_ascii),
        .invalid (lut_invalid)
    );

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q;
    logic          push, pop;

    assign code_if.code_ready = (count_q < CNT_FULL);
    assign push               = code_if.code_valid && code_if.code_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= lut_ascii;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            char_out    <= 8'h00;
            char_valid  <= 1'b0;
            err_invalid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push) char_out <= lut_ascii;
            char_valid  <= push;
            err_invalid <= push && lut_invalid;
            overflow    <= code_if.code_valid && !code_if.code_ready;
        end
    end

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;

    // tx and tx_busy are registered from the state, so the line lags the
    // FSM by one cycle and stays glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx      <= (state_q == TX_START) ? 1'b0 :
                       (state_q == TX_DATA)  ? sh_q[0] : 1'b1;
            tx_busy <= (state_q != TX_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    sh_d    = mem[rd_ptr];
                    state_d = TX_START;
                end
            end
            TX_START: if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = TX_DATA;
            end
            TX_DATA: if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                sh_d  = {1'b0, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = TX_STOP;
            end
            TX_STOP: if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_morse_char_uart_tx.sv
// Directed bench for morse_char_uart_tx: decode vectors, UART framing,
// FIFO overflow, mid-frame reset and back-to-back frame timing.
module tb_morse_char_uart_tx;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] char_out;
    logic       char_valid, err_invalid, overflow, tx, tx_busy;

    morse_char_uart_tx_if cif ();

    morse_char_uart_tx #(
        .CLK_FREQ_HZ (400),
        .BAUD        (100),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_if     (cif),
        .char_out    (char_out),
        .char_valid  (char_valid),
        .err_invalid (err_invalid),
        .overflow    (overflow),
        .tx          (tx),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART receiver sampling mid-bit on the falling edge.
    logic [7:0] rxq[$];
    logic [7:0] rsh = '0;
    int         mst = 0;
    int         fcnt = 0;
    int         mb = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mst  = 0;
            fcnt = 0;
        end else if (mst == 0) begin
            if (tx == 1'b0) begin
                mst  = 1;
                fcnt = 0;
            end
        end else begin
            fcnt++;
            if (fcnt % DIV == DIV / 2) begin
                mb = fcnt / DIV;
                if (mb == 0) chk("rx_start", 32'(tx), 32'(1'b0));
                else if (mb < 9) rsh[mb-1] = tx;
                else begin
                    chk("rx_stop", 32'(tx), 32'(1'b1));
                    rxq.push_back(rsh);
                    mst = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_rx(input logic [7:0] exp, input string tag);
        int i = 0;
        while (rxq.size() == 0 && i < 200) begin
            tick();
            i++;
        end
        if (rxq.size() == 0) chk({tag, "_timeout"}, 32'(rxq.size()), 32'd1);
        else chk(tag, 32'(rxq.pop_front()), 32'(exp));
    endtask

    task automatic wait_tx_low(input string tag);
        int i = 0;
        while (tx !== 1'b0 && i < 100) begin
            tick();
            i++;
        end
        chk(tag, 32'(tx), 32'(1'b0));
    endtask

    task automatic send_code(input logic [9:0] code, input logic [7:0] ech, input logic eerr);
        cif.code_in    = code;
        cif.code_valid = 1'b1;
        tick();
        cif.code_valid = 1'b0;
        chk("dec_valid", 32'(char_valid), 32'(1'b1));
        chk("dec_char", 32'(char_out), 32'(ech));
        chk("dec_err", 32'(err_invalid), 32'(eerr));
        expect_rx(ech, "dec_rx");
        ticks(DIV + 2);
    endtask

    logic [9:0] t4_code [7] = '{10'b00_00_00_00_10, 10'b00_00_00_00_11, 10'b00_00_00_10_10,
                                10'b00_00_00_10_11, 10'b00_00_00_11_10, 10'b00_00_00_11_11,
                                10'b00_00_10_10_10};
    logic [7:0] t4_ch [5] = '{8'h45, 8'h54, 8'h49, 8'h41, 8'h4E};
    logic [9:0] t1_frame = 10'b1_01000001_0;

    initial begin
        int lows;
        rst_n          = 1'b0;
        cif.code_in    = '0;
        cif.code_valid = 1'b0;
        ticks(3);
        chk("rst_tx", 32'(tx), 32'(1'b1));
        chk("rst_busy", 32'(tx_busy), 32'(1'b0));
        chk("rst_ready", 32'(cif.code_ready), 32'(1'b1));
        chk("rst_char", 32'(char_out), 32'h00);
        chk("rst_cv", 32'(char_valid), 32'(1'b0));
        chk("rst_err", 32'(err_invalid), 32'(1'b0));
        chk("rst_ovf", 32'(overflow), 32'(1'b0));
        rst_n = 1'b1;
        tick();

        // "A": exact latency and cycle-by-cycle frame
        cif.code_in    = 10'b00_00_00_10_11;
        cif.code_valid = 1'b1;
        tick();
        cif.code_valid = 1'b0;
        chk("a_cv", 32'(char_valid), 32'(1'b1));
        chk("a_char", 32'(char_out), 32'h41);
        chk("a_err", 32'(err_invalid), 32'(1'b0));
        chk("a_tx_e", 32'(tx), 32'(1'b1));
        tick();
        chk("a_cv_pulse", 32'(char_valid), 32'(1'b0));
        chk("a_tx_e1", 32'(tx), 32'(1'b1));
        tick();
        chk("a_tx_e2", 32'(tx), 32'(1'b0));
        chk("a_busy", 32'(tx_busy), 32'(1'b1));
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < DIV; k++) begin
                chk("a_frame", 32'(tx), 32'(t1_frame[b]));
                tick();
            end
        end
        chk("a_busy_end", 32'(tx_busy), 32'(1'b0));
        chk("a_tx_end", 32'(tx), 32'(1'b1));
        expect_rx(8'h41, "a_rx");
        ticks(4);

        // decode table and invalid/space cases
        send_code(10'b11_11_11_11_11, 8'h30, 1'b0);
        send_code(10'b10_10_10_10_10, 8'h35, 1'b0);
        send_code(10'b00_00_11_10_10, 8'h44, 1'b0);
        send_code(10'b00_11_11_10_11, 8'h51, 1'b0);
        send_code(10'b11_11_11_10_10, 8'h38, 1'b0);
        send_code(10'h000,            8'h20, 1'b0);
        send_code(10'b00_00_10_00_11, 8'h3F, 1'b1);
        send_code(10'b10_11_10_11_10, 8'h3F, 1'b1);
        send_code(10'b00_11_11_11_11, 8'h3F, 1'b1);

        // 7 back-to-back codes into a 4-deep FIFO
        for (int i = 0; i < 7; i++) begin
            cif.code_in    = t4_code[i];
            cif.code_valid = 1'b1;
            tick();
            chk("ovf_cv", 32'(char_valid), 32'(i < 5));
            chk("ovf_pulse", 32'(overflow), 32'(i >= 5));
            chk("ovf_ready", 32'(cif.code_ready), 32'(i < 4));
            if (i < 5) chk("ovf_char", 32'(char_out), 32'(t4_ch[i]));
        end
        cif.code_valid = 1'b0;
        tick();
        chk("ovf_clear", 32'(overflow), 32'(1'b0));
        for (int i = 0; i < 5; i++) expect_rx(t4_ch[i], "ovf_rx");
        ticks(12 * DIV);
        chk("ovf_no_extra", 32'(rxq.size()), 32'd0);
        chk("ovf_ready_back", 32'(cif.code_ready), 32'(1'b1));

        // reset during data bit 3 with a second char queued
        cif.code_in    = 10'b00_00_11_10_11;
        cif.code_valid = 1'b1;
        tick();
        cif.code_in    = 10'b00_00_10_11_10;
        tick();
        cif.code_valid = 1'b0;
        wait_tx_low("rst_mid_start");
        ticks(4 * DIV + 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(tx), 32'(1'b1));
        chk("rst_mid_busy", 32'(tx_busy), 32'(1'b0));
        chk("rst_mid_ready", 32'(cif.code_ready), 32'(1'b1));
        chk("rst_mid_char", 32'(char_out), 32'h00);
        ticks(2);
        rst_n = 1'b1;
        lows  = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx == 1'b0) lows++;
        end
        chk("rst_mid_quiet", 32'(lows), 32'd0);
        chk("rst_mid_rxq", 32'(rxq.size()), 32'd0);
        send_code(10'b00_00_10_10_10, 8'h53, 1'b0);

        // push in the final stop cycle: next start after one idle cycle
        cif.code_in    = 10'b00_00_00_11_11;
        cif.code_valid = 1'b1;
        tick();
        cif.code_valid = 1'b0;
        wait_tx_low("gap_start");
        ticks(10 * DIV - 2);
        cif.code_in    = 10'b00_00_00_00_11;
        cif.code_valid = 1'b1;
        tick();
        cif.code_valid = 1'b0;
        chk("gap_cv", 32'(char_valid), 32'(1'b1));
        chk("gap_stop_tx", 32'(tx), 32'(1'b1));
        chk("gap_stop_busy", 32'(tx_busy), 32'(1'b1));
        tick();
        chk("gap_idle_tx", 32'(tx), 32'(1'b1));
        tick();
        chk("gap_next_tx", 32'(tx), 32'(1'b0));
        chk("gap_next_busy", 32'(tx_busy), 32'(1'b1));
        expect_rx(8'h4D, "gap_rx0");
        expect_rx(8'h54, "gap_rx1");
        ticks(2 * DIV);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
